aspiradora_mode_scheduler: RTL and testbench

- Sequences the vacuum-cleaner Moore FSM by choosing its operating mode.
- Arbitrates four requesters by fixed priority: battery monitor, power button, bump sensor, start button.
- Enforces evade timing, evade retry limits and a cleaning-session timeout.
- Sits in the tt_um top level between the ui_in switches/sensors and the FSM mode inputs; hands each new mode over with a valid/ready handshake.

---
 rtl/aspiradora_pkg.sv | 16 +
 rtl/aspiradora_mode_scheduler_tick_prescaler.sv | 39 +++
 rtl/aspiradora_mode_scheduler.sv | 166 ++++++++++++++++
 tb/tb_aspiradora_mode_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aspiradora_pkg.sv
// Shared types and counter widths for the vacuum-cleaner mode scheduler.
package aspiradora_pkg;

  typedef enum logic [1:0] {
    POWER_OFF = 2'b00,
    ON        = 2'b01,
    CLEANING  = 2'b10,
    EVADING   = 2'b11
  } mode_t;

  // EVADE_TICKS must fit in EVADE_W bits, MAX_RETRY in RETRY_W bits.
  localparam int unsigned EVADE_W   = 8;
  localparam int unsigned RETRY_W   = 4;
  localparam int unsigned SESSION_W = 8;

endpackage

// File: rtl/aspiradora_mode_scheduler_tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every CLK_DIV enabled clocks.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..CLK_DIV-1 while enabled; tick flop mirrors "count is at its last value".
  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  // Prescaler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/aspiradora_mode_scheduler.sv
// Chooses the vacuum FSM operating mode from buttons/sensors with fixed priority,
// evade/session timing and a valid/ready command handshake.
module aspiradora_mode_scheduler
  import aspiradora_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 1000,
  parameter int unsigned EVADE_TICKS = 8,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CLEAN_TICKS = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 btn_power,
  input  logic                 btn_start,
  input  logic                 bump,
  input  logic                 batt_low,
  input  logic                 cmd_ready,
  output logic [1:0]           mode,
  output logic                 cmd_valid,
  output logic                 fault,
  output logic [SESSION_W-1:0] session_left
);

  mode_t                mode_q, mode_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 fault_q, fault_d;
  logic [SESSION_W-1:0] session_q, session_d;
  logic [EVADE_W-1:0]   evade_q, evade_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 pwr_prev_q, pwr_prev_d;
  logic                 start_prev_q, start_prev_d;

  logic                 tick;
  logic                 tick_en;
  logic                 pwr_edge;
  logic                 start_edge;
  logic                 off_req;
  logic                 blocked;
  logic                 sess_exp;
  logic                 evade_exp;
  logic [RETRY_W-1:0]   retry_inc;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick)
  );

  // Next-state: priority arbitration, timers and handshake bookkeeping.
  always_comb begin
    mode_d       = mode_q;
    cmd_valid_d  = cmd_valid_q;
    fault_d      = fault_q;
    session_d    = session_q;
    evade_d      = evade_q;
    retry_d      = retry_q;
    // Edge registers sample even while disabled so held presses are not replayed.
    pwr_prev_d   = btn_power;
    start_prev_d = btn_start;

    pwr_edge   = btn_power & ~pwr_prev_q;
    start_edge = btn_start & ~start_prev_q;
    tick_en    = tick & ena;
    off_req    = batt_low | pwr_edge;
    // An unaccepted command only lets power-off transitions through.
    blocked    = cmd_valid_q & ~cmd_ready;
    // Expiry is either already pending at zero or happens on this tick.
    sess_exp   = (session_q == '0) || (tick_en && (session_q == SESSION_W'(1)));
    evade_exp  = (evade_q == '0) || (tick_en && (evade_q == EVADE_W'(1)));
    retry_inc  = retry_q + RETRY_W'(1);

    if (ena) begin
      unique case (mode_q)
        POWER_OFF: begin
          if (pwr_edge && !batt_low && !blocked) begin
            mode_d  = ON;
            fault_d = 1'b0;
          end
        end
        ON: begin
          if (off_req) begin
            mode_d = POWER_OFF;
          end else if (start_edge && !fault_q && !blocked) begin
            mode_d    = CLEANING;
            session_d = SESSION_W'(CLEAN_TICKS);
          end
        end
        CLEANING: begin
          if (off_req) begin
            mode_d = POWER_OFF;
          end else if (bump && !blocked) begin
            mode_d  = EVADING;
            evade_d = EVADE_W'(EVADE_TICKS);
            retry_d = '0;
          end else if (start_edge && !blocked) begin
            mode_d = ON;
          end else if (sess_exp) begin
            session_d = '0;
            if (!blocked) begin
              mode_d = ON;
            end
          end else if (tick_en) begin
            session_d = session_q - SESSION_W'(1);
          end
        end
        EVADING: begin
          if (off_req) begin
            mode_d = POWER_OFF;
          end else if (evade_exp) begin
            evade_d = '0;
            if (!blocked) begin
              if (!bump) begin
                mode_d = CLEANING;
              end else if (retry_inc == RETRY_W'(MAX_RETRY)) begin
                mode_d  = ON;
                fault_d = 1'b1;
                retry_d = retry_inc;
              end else begin
                evade_d = EVADE_W'(EVADE_TICKS);
                retry_d = retry_inc;
              end
            end
          end else if (tick_en) begin
            evade_d = evade_q - EVADE_W'(1);
          end
        end
        default: mode_d = POWER_OFF;
      endcase

      cmd_valid_d = (mode_d != mode_q) | (cmd_valid_q & ~cmd_ready);
    end
  end

  // State, counters and edge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= POWER_OFF;
      cmd_valid_q  <= 1'b0;
      fault_q      <= 1'b0;
      session_q    <= '0;
      evade_q      <= '0;
      retry_q      <= '0;
      pwr_prev_q   <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      cmd_valid_q  <= cmd_valid_d;
      fault_q      <= fault_d;
      session_q    <= session_d;
      evade_q      <= evade_d;
      retry_q      <= retry_d;
      pwr_prev_q   <= pwr_prev_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign mode         = mode_q;
  assign cmd_valid    = cmd_valid_q;
  assign fault        = fault_q;
  assign session_left = session_q;

endmodule

// File: tb/tb_aspiradora_mode_scheduler.sv
// Scoreboard bench for the mode scheduler: reference model predicts each mode
// command and per-cycle status; a monitor checks what the DUT presents.
module tb_aspiradora_mode_scheduler;

  localparam int CLK_DIV     = 4;
  localparam int EVADE_TICKS = 3;
  localparam int MAX_RETRY   = 2;
  localparam int CLEAN_TICKS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       btn_power = 1'b0;
  logic       btn_start = 1'b0;
  logic       bump = 1'b0;
  logic       batt_low = 1'b0;
  logic       cmd_ready = 1'b1;
  logic [1:0] mode;
  logic       cmd_valid;
  logic       fault;
  logic [7:0] session_left;

  aspiradora_mode_scheduler #(
    .CLK_DIV     (CLK_DIV),
    .EVADE_TICKS (EVADE_TICKS),
    .MAX_RETRY   (MAX_RETRY),
    .CLEAN_TICKS (CLEAN_TICKS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .btn_power    (btn_power),
    .btn_start    (btn_start),
    .bump         (bump),
    .batt_low     (batt_low),
    .cmd_ready    (cmd_ready),
    .mode         (mode),
    .cmd_valid    (cmd_valid),
    .fault        (fault),
    .session_left (session_left)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int mode;
    int fault;
    int sess;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (plain integers, behaviour written from the mode rules).
  int m_mode, m_sess, m_evade, m_retry, m_clocks;
  bit m_fault, m_valid, m_pwr_prev, m_start_prev;
  int exp_valid, exp_fault, exp_sess;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sess = 0; m_evade = 0; m_retry = 0; m_clocks = 0;
    m_fault = 0; m_valid = 0; m_pwr_prev = 0; m_start_prev = 0;
    exp_valid = 0; exp_fault = 0; exp_sess = 0;
    exp_q.delete();
  endtask

  // Predict what the DUT does at the next rising edge with the inputs now applied.
  task automatic model_step();
    bit   pwr_press, start_press, tick_now, stalled, go_off;
    int   next_mode;
    exp_t e;
    pwr_press   = btn_power && !m_pwr_prev;
    start_press = btn_start && !m_start_prev;
    m_pwr_prev   = btn_power;
    m_start_prev = btn_start;
    if (ena) begin
      tick_now = ((m_clocks % CLK_DIV) == CLK_DIV - 1);
      m_clocks++;
      stalled   = m_valid && !cmd_ready;
      go_off    = batt_low || pwr_press;
      next_mode = m_mode;
      case (m_mode)
        0: if (pwr_press && !batt_low && !stalled) begin next_mode = 1; m_fault = 0; end
        1: begin
          if (go_off) next_mode = 0;
          else if (start_press && !m_fault && !stalled) begin next_mode = 2; m_sess = CLEAN_TICKS; end
        end
        2: begin
          if (go_off) next_mode = 0;
          else if (bump && !stalled) begin next_mode = 3; m_evade = EVADE_TICKS; m_retry = 0; end
          else if (start_press && !stalled) next_mode = 1;
          else begin
            if (tick_now && m_sess > 0) m_sess--;
            if (m_sess == 0 && !stalled) next_mode = 1;
          end
        end
        default: begin
          if (go_off) next_mode = 0;
          else begin
            if (tick_now && m_evade > 0) m_evade--;
            if (m_evade == 0 && !stalled) begin
              if (!bump) next_mode = 2;
              else begin
                m_retry++;
                if (m_retry >= MAX_RETRY) begin next_mode = 1; m_fault = 1; end
                else m_evade = EVADE_TICKS;
              end
            end
          end
        end
      endcase
      m_valid = (next_mode != m_mode) || (m_valid && !cmd_ready);
      if (next_mode != m_mode) begin
        e.cyc = cyc + 1; e.mode = next_mode; e.fault = int'(m_fault); e.sess = m_sess;
        exp_q.push_back(e);
      end
      m_mode = next_mode;
    end
    exp_valid = int'(m_valid);
    exp_fault = int'(m_fault);
    exp_sess  = m_sess;
  endtask

  task automatic drive(input bit p, input bit s, input bit b, input bit bl,
                       input bit rdy, input bit en);
    @(negedge clk);
    btn_power = p; btn_start = s; bump = b; batt_low = bl; cmd_ready = rdy; ena = en;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    btn_power = 0; btn_start = 0; bump = 0; batt_low = 0; cmd_ready = 1; ena = 1;
    #1;
    chk("reset_mode", 32'(mode), 0);
    chk("reset_cmd_valid", 32'(cmd_valid), 0);
    chk("reset_fault", 32'(fault), 0);
    chk("reset_session_left", 32'(session_left), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_step();
  endtask

  task automatic to_cleaning();
    do_reset();
    idle(2);
    drive(1, 0, 0, 0, 1, 1);
    idle(3);
    drive(0, 1, 0, 0, 1, 1);
    idle(2);
  endtask

  // Monitor: pop an expected command whenever the DUT presents a new mode.
  logic [1:0] prev_mode = 2'b00;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missing_cmd_mode", 32'(prev_mode), 32'(e.mode));
      end
      if (mode !== prev_mode) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd_mode", 32'(mode), 32'(prev_mode));
        end else begin
          e = exp_q.pop_front();
          chk("cmd_cycle", 32'(cyc), 32'(e.cyc));
          chk("cmd_mode", 32'(mode), 32'(e.mode));
          chk("cmd_fault", 32'(fault), 32'(e.fault));
          chk("cmd_session_left", 32'(session_left), 32'(e.sess));
        end
      end
      chk("cmd_valid", 32'(cmd_valid), 32'(exp_valid));
      chk("fault", 32'(fault), 32'(exp_fault));
      chk("session_left", 32'(session_left), 32'(exp_sess));
    end
    prev_mode = mode;
  end

  initial begin
    bit p_lvl, s_lvl, b_lvl, bl_lvl;

    // Power pulse: OFF -> ON, one-cycle cmd_valid.
    do_reset();
    idle(2);
    drive(1, 0, 0, 0, 1, 1);
    idle(4);

    // Start pulse, then session runs out.
    drive(0, 1, 0, 0, 1, 1);
    idle(45);

    // Short bump: evade then back to cleaning with session retained.
    to_cleaning();
    idle(5);
    drive(0, 0, 1, 0, 1, 1);
    drive(0, 0, 1, 0, 1, 1);
    idle(16);

    // Bump held: retry exhaustion -> ON with fault; start then ignored.
    to_cleaning();
    for (int i = 0; i < 30; i++) drive(0, 0, 1, 0, 1, 1);
    idle(3);
    drive(0, 1, 0, 0, 1, 1);
    idle(5);

    // Stalled handshake: start lost, battery low overwrites, valid held.
    do_reset();
    idle(1);
    drive(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 1, 1);
    idle(3);

    // Battery low with power press together, then power press while battery low.
    to_cleaning();
    idle(3);
    drive(1, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    drive(1, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    idle(3);

    // Bump together with start while cleaning -> evading.
    to_cleaning();
    drive(0, 1, 1, 0, 1, 1);
    idle(20);

    // Disabled: presses dropped, timers frozen.
    to_cleaning();
    for (int i = 0; i < 10; i++) drive(0, i == 3, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 0);
    idle(6);

    // Reset mid-operation.
    to_cleaning();
    idle(3);
    do_reset();
    idle(3);

    // Randomised traffic.
    p_lvl = 0; s_lvl = 0; b_lvl = 0; bl_lvl = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 2999) == 0) begin
        do_reset();
        p_lvl = 0; s_lvl = 0; b_lvl = 0; bl_lvl = 0;
      end
      if ($urandom_range(0, 59) == 0) p_lvl = ~p_lvl;
      if ($urandom_range(0, 11) == 0) s_lvl = ~s_lvl;
      if ($urandom_range(0, 24) == 0) b_lvl = ~b_lvl;
      if (bl_lvl) bl_lvl = ($urandom_range(0, 9) != 0);
      else        bl_lvl = ($urandom_range(0, 399) == 0);
      drive(p_lvl, s_lvl, b_lvl, bl_lvl, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) != 0);
    end
    idle(4);

    @(negedge clk);
    chk("pending_cmds_left", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
